// File: rtl/dram_readout_pkg.sv
// Shared types and constants for the distributed-RAM DPO read-back sequencer.
package dram_readout_pkg;

  localparam int ADDR_W          = 6;
  localparam int BYTES_PER_SWEEP = 16;
  localparam int ADDRS_PER_BYTE  = 4;

  localparam logic [7:0] HEADER_DEFAULT = 8'hA5;

  typedef enum logic [2:0] {
    IDLE,
    HDR,
    READ,
    SEND,
    CSUM
  } state_t;

endpackage

// File: rtl/dram_dpo_readout_if.sv
// Read port shared by the two 64x1 dual-port RAMs: one address out, one DPO bit per RAM back.
interface dram_dpo_readout_if;
  import dram_readout_pkg::*;

  logic [ADDR_W-1:0] dpra;
  logic [1:0]        dpo;

  modport master (output dpra, input dpo);
  modport slave  (input dpra, output dpo);

endinterface

// File: rtl/uart_tx_8n1.sv
// UART 8N1 transmitter with a valid/ready byte input; ready only while the line is idle.
module uart_tx_8n1 #(
  parameter int CLKS_PER_BIT = 868
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       valid,
  output logic       ready,
  output logic       tx
);

  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

  logic             active_q, active_d;
  logic [9:0]       shift_q, shift_d;
  logic [CNT_W-1:0] baud_q, baud_d;
  logic [3:0]       bit_q, bit_d;
  logic             tx_q, tx_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active_q <= 1'b0;
      shift_q  <= '1;
      baud_q   <= '0;
      bit_q    <= '0;
      tx_q     <= 1'b1;
    end else begin
      active_q <= active_d;
      shift_q  <= shift_d;
      baud_q   <= baud_d;
      bit_q    <= bit_d;
      tx_q     <= tx_d;
    end
  end

  // shift_q[0] is the bit currently on the line; ones shift in behind the stop bit.
  always_comb begin
    active_d = active_q;
    shift_d  = shift_q;
    baud_d   = baud_q;
    bit_d    = bit_q;
    tx_d     = tx_q;
    if (!active_q) begin
      tx_d = 1'b1;
      if (valid) begin
        active_d = 1'b1;
        shift_d  = {1'b1, data, 1'b0};
        baud_d   = '0;
        bit_d    = '0;
        tx_d     = 1'b0;
      end
    end else if (baud_q == BAUD_LAST) begin
      baud_d = '0;
      if (bit_q == 4'd9) begin
        active_d = 1'b0;
      end else begin
        shift_d = {1'b1, shift_q[9:1]};
        tx_d    = shift_q[1];
        bit_d   = bit_q + 4'd1;
      end
    end else begin
      baud_d = baud_q + CNT_W'(1);
    end
  end

  assign ready = !active_q;
  assign tx    = tx_q;

endmodule

// File: rtl/dram_dpo_readout.sv
// Sweeps DPRA 0..63 over two 64x1 LUTRAMs and streams header, 16 packed bytes and XOR checksum over UART.
module dram_dpo_readout
  import dram_readout_pkg::*;
#(
  parameter int         CLKS_PER_BIT = 868,
  parameter logic [7:0] HEADER       = HEADER_DEFAULT
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  dram_dpo_readout_if.master ram,
  output logic               tx,
  output logic               busy,
  output logic               done
);

  localparam logic [1:0] LAST_K = 2'(ADDRS_PER_BYTE - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              phase_q, phase_d;
  logic              sent_q, sent_d;
  logic [7:0]        byte_q, byte_d;
  logic [7:0]        csum_q, csum_d;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic              tx_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      addr_q  <= '0;
      phase_q <= 1'b0;
      sent_q  <= 1'b0;
      byte_q  <= '0;
      csum_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      phase_q <= phase_d;
      sent_q  <= sent_d;
      byte_q  <= byte_d;
      csum_q  <= csum_d;
    end
  end

  // READ spends one settle cycle after each address change, then captures both DPO bits.
  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    phase_d  = phase_q;
    sent_d   = sent_q;
    byte_d   = byte_q;
    csum_d   = csum_q;
    tx_valid = 1'b0;
    tx_data  = byte_q;
    done     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = HDR;
          addr_d  = '0;
          phase_d = 1'b0;
          sent_d  = 1'b0;
          csum_d  = '0;
        end
      end
      HDR: begin
        tx_valid = 1'b1;
        tx_data  = HEADER;
        if (tx_ready) state_d = READ;
      end
      READ: begin
        if (!phase_q) begin
          phase_d = 1'b1;
        end else begin
          phase_d = 1'b0;
          byte_d[{addr_q[1:0], 1'b0} +: 2] = ram.dpo;
          addr_d = addr_q + ADDR_W'(1);
          if (addr_q[1:0] == LAST_K) state_d = SEND;
        end
      end
      SEND: begin
        tx_valid = 1'b1;
        if (tx_ready) begin
          csum_d  = csum_q ^ byte_q;
          state_d = (addr_q == '0) ? CSUM : READ;
        end
      end
      CSUM: begin
        tx_data  = csum_q;
        tx_valid = !sent_q;
        if (!sent_q) begin
          if (tx_ready) sent_d = 1'b1;
        end else if (tx_ready) begin
          // Transmitter is idle again: the checksum stop bit has just finished.
          done    = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign busy     = (state_q != IDLE) && !done;
  assign ram.dpra = addr_q;

  uart_tx_8n1 #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_uart_tx (
    .clk   (clk),
    .rst_n (rst_n),
    .data  (tx_data),
    .valid (tx_valid),
    .ready (tx_ready),
    .tx    (tx)
  );

endmodule

// File: doc/dram_dpo_readout.md
# dram_dpo_readout

Autonomous read-port sequencer for a pair of 64x1 dual-port distributed RAMs on xc7 test designs. On a start request it sweeps the shared DPRA address from 0 to 63 and samples both DPO outputs. It packs the 128 bits into 16 bytes and streams them, framed by a header and an XOR checksum, over a UART 8N1 transmitter on the board `tx` pin. It is the read-back counterpart of the switch-driven write path, so the host can dump RAM contents without stepping DPRA switches by hand.

## Interface
Parameters:
- `CLKS_PER_BIT`, default 868: clock cycles per UART bit (100 MHz / 115200); legal range 2..65535.
- `HEADER`, default 8'hA5: frame start byte.

Ports:
- `clk` in 1: sole clock; all logic on its rising edge.
- `rst_n` in 1: reset, asynchronous and active-low.
- `start` in 1: single-cycle sweep request; sampled only in IDLE.
- `dpra` out 6: read address driven to both RAMs' DPRA5..DPRA0.
- `dpo` in 2: `dpo[0]` is RAM0's DPO and `dpo[1]` is RAM1's DPO; combinational (LUTRAM async read).
- `tx` out 1: UART serial out, idle high.
- `busy` out 1: high from the cycle after `start` is accepted until the checksum stop bit completes.
- `done` out 1: one-cycle pulse in the cycle `busy` falls.

## Operation
- Reset values: `tx`=1, `dpra`=0, `busy`=0, `done`=0; FSM in IDLE; address counter, byte register and checksum are 0.
- FSM states: IDLE, HDR, READ, SEND, CSUM.
  - IDLE: on `start`=1, go to HDR.
  - HDR: transmit `HEADER`. When the transmitter accepts it, go to READ.
  - READ: sample 4 consecutive addresses into the byte register, then go to SEND.
  - SEND: transmit the byte and XOR it into the checksum. On accept, if the address counter has wrapped to 0, go to CSUM; otherwise go to READ.
  - CSUM: transmit the checksum. After its stop bit ends, go to IDLE and pulse `done`.
- Byte packing: for address a = 4*i + k (byte i, k=0..3):
  - bit[2k] = `dpo[0]`;
  - bit[2k+1] = `dpo[1]`.
- The address counter is 6 bits and wraps 63→0. Wrap marks the end of the data phase.
- Checksum is the XOR of the 16 data bytes. `HEADER` is not included.
- `start` is ignored while `busy`=1; it is neither queued nor restarting the sweep.
- Transmitter handshake: valid/ready.
  - A byte is accepted in the cycle both `valid` and `ready` are high.
  - `ready` is high only while the transmitter line is idle.
  - `valid` holds until accepted, and the byte holds stable while `valid` is high.
- `rst_n` low mid-frame: every output returns to its reset value immediately. The partial frame is abandoned; the host detects this by the missing checksum.

## Timing
- `start` is accepted at edge N: `busy`=1 from N+1, and the HDR start bit appears on `tx` at N+2.
- READ, per address:
  - `dpra` updates on cycle c;
  - `dpo` is registered at the end of c+1 (one settle cycle);
  - 2 cycles per address, 8 cycles per byte.
- The next byte's READ overlaps transmission of the current byte. The transmitter therefore never idles between bytes longer than 1 cycle (the handshake cycle).
- UART bit = `CLKS_PER_BIT` cycles. Frame = start(0), 8 data bits LSB first, stop(1).
- Total frame: 18 bytes × 10 bits, plus at most 1 cycle per byte of handshake gap.
- `done` pulses exactly 10×`CLKS_PER_BIT` cycles after the checksum is accepted, in the same cycle `busy` falls.

## Structure
- Shared package `dram_readout_pkg`:
  - FSM state enum;
  - `HEADER` default;
  - constants `ADDR_W`=6, `BYTES_PER_SWEEP`=16, `ADDRS_PER_BYTE`=4.
- Sub-module `uart_tx_8n1`:
  - parameter `CLKS_PER_BIT`;
  - ports `clk`, `rst_n`, `data[7:0]`, `valid`, `ready`, `tx`;
  - contains the baud counter and the 10-bit shift register.
- Top FSM, address counter, packing and checksum live in `dram_dpo_readout`.

## Test plan
Bench uses `CLKS_PER_BIT`=4 with two behavioral 64x1 async-read RAM models.

- Both RAMs INIT=64'h2; pulse `start` → bytes A5, 0C, then fifteen 00, then checksum 0C; `done` pulses once and `busy` falls in the same cycle.
- RAM0 all ones, RAM1 all zeros → 16 bytes of 55, checksum 00. Swap the contents → AA ×16, checksum 00.
- `start` held high throughout a sweep → exactly one frame, then a second frame starting 1 cycle after `done` (`start` still high in IDLE).
- `rst_n` low during the 5th data byte → `tx`=1, `dpra`=0 and `busy`=0 within the same cycle. A new `start` then yields a complete, correct frame.
- Check `dpra` on every cycle of READ → it steps 0..63 in order, 2 cycles per value, with no repeats or skips across byte boundaries.
- Decode every bit period on `tx` → start bit 0 and stop bit 1, each bit exactly 4 cycles wide, idle high between frames.
